// File: rtl/commutator_lane_arbiter.sv
// Round-robin lane arbiter for the 5-to-3 commutator: N_IN requesters share N_OUT lanes.
// Optional per-lane hold timeout is enabled by defining COMMUTATOR_ARB_TIMEOUT_EN.
module commutator_lane_arbiter #(
  parameter int N_IN     = 5,
  parameter int N_OUT    = 3,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN-1:0]        req,
  output logic [N_IN-1:0]        grant,
  output logic [N_OUT*SEL_W-1:0] lane_sel,
  output logic [N_OUT-1:0]       lane_vld,
  output logic                   busy
);

  logic [N_IN-1:0]        grant_q, grant_d;
  logic [N_OUT*SEL_W-1:0] lane_sel_q, lane_sel_d;
  logic [N_OUT-1:0]       lane_vld_q, lane_vld_d;
  logic                   busy_q, busy_d;
  logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic [N_IN-1:0]        cand_s;
  logic [N_OUT-1:0]       free_s;
  logic [N_OUT-1:0]       lane_new_s;
  logic [N_OUT-1:0]       revoke_s;
  logic [SEL_W-1:0]       revoke_ptr_s;
  logic                   any_revoke_s;
  logic                   any_grant_s;
  logic                   found_s;

`ifdef COMMUTATOR_ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  logic [N_OUT-1:0][HOLD_W-1:0] hold_q, hold_d;

  // Revoke a lane that reached its hold limit while someone else is waiting.
  always_comb begin
    revoke_s = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (lane_vld_q[k] && (hold_q[k] == HOLD_W'(MAX_HOLD - 1)) && (|cand_s)) begin
        revoke_s[k] = 1'b1;
      end else begin
        revoke_s[k] = 1'b0;
      end
    end
  end

  // Hold counters restart on a new grant and saturate while the lane stays owned.
  always_comb begin
    hold_d = hold_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (lane_new_s[k]) begin
        hold_d[k] = '0;
      end else if (lane_vld_q[k] && (hold_q[k] != {HOLD_W{1'b1}})) begin
        hold_d[k] = hold_q[k] + HOLD_W'(1);
      end else begin
        hold_d[k] = hold_q[k];
      end
    end
  end

  // Hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // Without the timeout, lanes are only ever released by their owner.
  always_comb begin
    revoke_s = '0;
  end
`endif

  // Release and allocation evaluated on pre-edge state; released lanes stay free for one cycle.
  always_comb begin
    grant_d      = grant_q;
    lane_vld_d   = lane_vld_q;
    lane_sel_d   = lane_sel_q;
    rr_ptr_d     = rr_ptr_q;
    cand_s       = req & ~grant_q;
    free_s       = ~lane_vld_q;
    lane_new_s   = '0;
    revoke_ptr_s = rr_ptr_q;
    any_revoke_s = 1'b0;
    any_grant_s  = 1'b0;
    found_s      = 1'b0;

    for (int k = 0; k < N_OUT; k++) begin
      for (int j = 0; j < N_IN; j++) begin
        if (lane_vld_q[k] && (lane_sel_q[k*SEL_W +: SEL_W] == SEL_W'(j)) &&
            (!req[j] || revoke_s[k])) begin
          lane_vld_d[k] = 1'b0;
          grant_d[j]    = 1'b0;
          if (revoke_s[k]) begin
            any_revoke_s = 1'b1;
            revoke_ptr_s = (j == N_IN - 1) ? '0 : SEL_W'(j + 1);
          end else begin
            any_revoke_s = any_revoke_s;
          end
        end else begin
          lane_vld_d[k] = lane_vld_d[k];
        end
      end
    end

    // Pass 0 scans rr_ptr..N_IN-1, pass 1 wraps around to 0..rr_ptr-1.
    for (int pass = 0; pass < 2; pass++) begin
      for (int j = 0; j < N_IN; j++) begin
        if (((pass == 0) == (SEL_W'(j) >= rr_ptr_q)) && cand_s[j]) begin
          found_s = 1'b0;
          for (int k = 0; k < N_OUT; k++) begin
            if (!found_s && free_s[k]) begin
              found_s                       = 1'b1;
              free_s[k]                     = 1'b0;
              lane_new_s[k]                 = 1'b1;
              lane_vld_d[k]                 = 1'b1;
              lane_sel_d[k*SEL_W +: SEL_W]  = SEL_W'(j);
              grant_d[j]                    = 1'b1;
              any_grant_s                   = 1'b1;
              rr_ptr_d                      = (j == N_IN - 1) ? '0 : SEL_W'(j + 1);
            end else begin
              found_s = found_s;
            end
          end
        end else begin
          found_s = found_s;
        end
      end
    end

    if (!any_grant_s && any_revoke_s) begin
      rr_ptr_d = revoke_ptr_s;
    end else begin
      rr_ptr_d = rr_ptr_d;
    end

    busy_d = &lane_vld_d;
  end

  // Arbitration state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q    <= '0;
      lane_sel_q <= '0;
      lane_vld_q <= '0;
      busy_q     <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      grant_q    <= grant_d;
      lane_sel_q <= lane_sel_d;
      lane_vld_q <= lane_vld_d;
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign grant    = grant_q;
  assign lane_sel = lane_sel_q;
  assign lane_vld = lane_vld_q;
  assign busy     = busy_q;

endmodule
